// File: rtl/prog_loader.sv
// prog_loader: boot-stage program loader.
// Receives a program over a UART line (8N1, LSB first) and writes it word by
// word into instruction memory. The core is held (cpu_run=0) until the whole
// program has been written.
//
// Byte stream: len[7:0], len[15:8], then len little-endian 32-bit words.
// len==0 releases the core at once; len > 2^ADDR_W is rejected.
//
// Optional feature (macro PROG_LOADER_CHECKSUM_EN): after the last word, one
// extra byte equal to the XOR of all payload bytes is expected (WAIT_CSUM).
//
// Ports:
//   clk       system clock, all state on posedge
//   rst_n     asynchronous active-low reset
//   rx        UART line, idle high, asynchronous to clk
//   im_we     one-cycle write strobe per assembled word
//   im_addr   byte address of the word being written (word_index*4)
//   im_wdata  assembled instruction word (first byte = bits [7:0])
//   cpu_run   high once the load has completed
//   busy      high while a header was accepted and words remain
//   err       sticky error flag (framing error, bad length, bad checksum)
//   state_dbg current loader FSM state encoding
module prog_loader #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_run,
  output logic        busy,
  output logic        err,
  output logic [2:0]  state_dbg
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  // ---------------- UART receiver ----------------
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  rx_state_t        rx_state;
  logic             rx_meta, rx_s, rx_prev;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;
  logic             byte_valid, frame_err;

  // Stop-bit sample decides the frame outcome in the same cycle, so the
  // loader FSM reacts at the very edge that samples the stop bit.
  assign byte_valid = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && rx_s;
  assign frame_err  = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && !rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt  <= '0;
            bit_idx <= '0;
            // Line back high at mid start bit: treat as a glitch.
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            bit_idx <= bit_idx + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) rx_state <= RX_WAIT_HIGH;
          else                    rx_cnt   <= rx_cnt + 1'b1;
        end
        RX_WAIT_HIGH: begin
          if (rx_s) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- loader FSM ----------------
  typedef enum logic [2:0] {
    WAIT_LEN0 = 3'd0,
    WAIT_LEN1 = 3'd1,
    WAIT_WORD = 3'd2,
    DONE      = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
    WAIT_CSUM = 3'd5,
`endif
    ERROR     = 3'd4
  } ld_state_t;

  ld_state_t     state;
  logic [15:0]   len;
  logic [23:0]   word_buf;   // lanes 0..2; im_wdata only updates with im_we
  logic [1:0]    byte_cnt;
  logic [ADDR_W:0] word_index;
  logic [15:0]   hdr_len;
  logic          last_word;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  assign state_dbg = state;
  assign hdr_len   = {rx_shift, len[7:0]};
  assign last_word = (32'(word_index) + 32'd1) == 32'(len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_LEN0;
      len        <= '0;
      word_buf   <= '0;
      byte_cnt   <= '0;
      word_index <= '0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_run    <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      im_we <= 1'b0;
      if (frame_err && state != DONE && state != ERROR) begin
        err   <= 1'b1;
        busy  <= 1'b0;
        state <= ERROR;
      end else begin
        case (state)
          WAIT_LEN0: begin
            if (byte_valid) begin
              len[7:0] <= rx_shift;
              state    <= WAIT_LEN1;
            end
          end
          WAIT_LEN1: begin
            if (byte_valid) begin
              len[15:8] <= rx_shift;
              if (hdr_len == 16'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                state <= WAIT_CSUM;
`else
                state <= DONE;
`endif
              end else if (32'(hdr_len) > (32'd1 << ADDR_W)) begin
                err   <= 1'b1;
                state <= ERROR;
              end else begin
                busy  <= 1'b1;
                state <= WAIT_WORD;
              end
            end
          end
          WAIT_WORD: begin
            if (byte_valid) begin
              byte_cnt <= byte_cnt + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
              csum <= csum ^ rx_shift;
`endif
              case (byte_cnt)
                2'd0: word_buf[7:0]   <= rx_shift;
                2'd1: word_buf[15:8]  <= rx_shift;
                2'd2: word_buf[23:16] <= rx_shift;
                default: begin
                  im_we      <= 1'b1;
                  im_wdata   <= {rx_shift, word_buf};
                  im_addr    <= 32'({word_index, 2'b00});
                  word_index <= word_index + 1'b1;
                  if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state <= WAIT_CSUM;
`else
                    busy  <= 1'b0;
                    state <= DONE;
`endif
                  end
                end
              endcase
            end
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          WAIT_CSUM: begin
            if (byte_valid) begin
              busy <= 1'b0;
              if (rx_shift == csum) begin
                state <= DONE;
              end else begin
                err   <= 1'b1;
                state <= ERROR;
              end
            end
          end
`endif
          DONE: cpu_run <= 1'b1;
          ERROR: begin
            cpu_run <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b1;
          end
          default: state <= ERROR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: UART byte driver, a write scoreboard
// fed with hand-computed expected (addr,data) pairs, and a negedge monitor
// that pops and compares on every im_we pulse.
module tb_prog_loader;
  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int CPB    = 10;
  localparam int ADDR_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic rx;
  always #5 clk = ~clk;

  logic        im_we, cpu_run, busy, err;
  logic [31:0] im_addr, im_wdata;
  logic [2:0]  state_dbg;

  prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_run(cpu_run), .busy(busy), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_we_cyc = -1;
  int run_rise_cyc = -1;
  int n_writes = 0;
  logic busy_seen = 1'b0;
  logic run_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected (addr,data) per write strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (im_we) begin
        n_writes++;
        last_we_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", im_addr, im_wdata);
        end else begin
          check("write", {im_addr, im_wdata}, exp_q.pop_front());
        end
      end
      if (busy) busy_seen = 1'b1;
      if (cpu_run && !run_prev) run_rise_cyc = cyc;
      run_prev = cpu_run;
    end else begin
      run_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i], 1'b1);
  endtask

  // Checksum byte is only part of the protocol when the feature is built in.
  task automatic end_payload(input logic [7:0] c);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_byte(c, 1'b1);
`else
    if (c !== c) $display("unreachable");
`endif
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    busy_seen = 1'b0;
    n_writes = 0;
  endtask

  task automatic check_cleared(input string name);
    check({name, "_outs"}, 64'({im_we, im_addr, im_wdata, cpu_run, busy, err}), 64'd0);
    check({name, "_state"}, 64'(state_dbg), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset_low");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_cleared("reset_released");

    // Two-word program.
    exp_q.push_back({32'h0, 32'h00000013});
    exp_q.push_back({32'h4, 32'h00100093});
    send_seq('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00});
    end_payload(8'h90);
    repeat (5) @(negedge clk);
    check("two_word_q_empty", 64'(exp_q.size()), 64'd0);
    check("two_word_writes", 64'(n_writes), 64'd2);
    check("two_word_run", 64'({cpu_run, busy, err}), 64'b100);
    check("two_word_state", 64'(state_dbg), 64'd3);
    check("two_word_busy_seen", 64'(busy_seen), 64'd1);
    check("two_word_held_data", 64'({im_addr, im_wdata}), {32'h4, 32'h00100093});
`ifndef PROG_LOADER_CHECKSUM_EN
    check("run_latency", 64'(run_rise_cyc), 64'(last_we_cyc + 1));
`endif

    // Empty program.
    do_reset();
    send_seq('{8'h00, 8'h00});
    end_payload(8'h00);
    repeat (3) @(negedge clk);
    check("len0_run", 64'({cpu_run, err}), 64'b10);
    check("len0_writes", 64'(n_writes), 64'd0);
    check("len0_busy_seen", 64'(busy_seen), 64'd0);

    // Length one past capacity (capacity is 4 words).
    do_reset();
    send_seq('{8'h05, 8'h00});
    repeat (3) @(negedge clk);
    check("len5_flags", 64'({cpu_run, busy, err}), 64'b001);
    check("len5_state", 64'(state_dbg), 64'd4);
    check("len5_writes", 64'(n_writes), 64'd0);

    // Full-capacity load, last address 0xC.
    do_reset();
    exp_q.push_back({32'h0, 32'h13121110});
    exp_q.push_back({32'h4, 32'h17161514});
    exp_q.push_back({32'h8, 32'h1B1A1918});
    exp_q.push_back({32'hC, 32'h1F1E1D1C});
    send_seq('{8'h04, 8'h00});
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b1);
    end_payload(8'h00);
    repeat (3) @(negedge clk);
    check("full_q_empty", 64'(exp_q.size()), 64'd0);
    check("full_writes", 64'(n_writes), 64'd4);
    check("full_run", 64'({cpu_run, err}), 64'b10);

    // Framing error on the 3rd payload byte.
    do_reset();
    send_seq('{8'h01, 8'h00, 8'hAA, 8'hBB});
    send_byte(8'hCC, 1'b0);
    repeat (3) @(negedge clk);
    check("frame_flags", 64'({cpu_run, busy, err}), 64'b001);
    check("frame_state", 64'(state_dbg), 64'd4);
    check("frame_writes", 64'(n_writes), 64'd0);
    do_reset();
    check_cleared("after_frame_reset");
    exp_q.push_back({32'h0, 32'hDDCCBBAA});
    send_seq('{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
    end_payload(8'h00);
    repeat (3) @(negedge clk);
    check("reload_q_empty", 64'(exp_q.size()), 64'd0);
    check("reload_run", 64'({cpu_run, err}), 64'b10);

    // Short glitch on an idle line, then async reset mid-word.
    do_reset();
    send_seq('{8'h02, 8'h00});
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_state", 64'(state_dbg), 64'd2);
    check("glitch_flags", 64'({busy, err}), 64'b10);
    exp_q.push_back({32'h0, 32'hDDCCBBAA});
    send_seq('{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22});
    check("glitch_q_empty", 64'(exp_q.size()), 64'd0);
    check("glitch_writes", 64'(n_writes), 64'd1);
    check("hold_data", 64'({im_addr, im_wdata, busy}), {32'h0, 32'hDDCCBBAA, 1'b1});
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_cleared("async_reset");
    @(negedge clk) rst_n = 1'b1;

`ifdef PROG_LOADER_CHECKSUM_EN
    do_reset();
    exp_q.push_back({32'h0, 32'h44332211});
    send_seq('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44});
    repeat (3) @(negedge clk);
    check("csum_ok_state", 64'(state_dbg), 64'd3);
    check("csum_ok_run", 64'({cpu_run, err}), 64'b10);
    do_reset();
    exp_q.push_back({32'h0, 32'h44332211});
    send_seq('{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45});
    repeat (3) @(negedge clk);
    check("csum_bad_flags", 64'({cpu_run, err}), 64'b01);
    check("csum_bad_state", 64'(state_dbg), 64'd4);
`endif

    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
